// File: rtl/ad_ip_jesd204_link_dnconv_phase_ctrl_pkg.sv
// Shared types and constants for the JESD204 down-converter phase controller:
// FSM encodings, SOF half-beat phase values and counter widths.
package ad_ip_jesd204_link_dnconv_phase_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_CHECK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam logic PHASE_LO = 1'b0;
  localparam logic PHASE_HI = 1'b1;

  localparam int ERR_CNT_W   = 8;
  localparam int SMALL_CNT_W = 4;

endpackage

// File: rtl/ad_ip_jesd204_sof_phase_detect.sv
// Flags a valid beat carrying SOF and reports which half of the beat holds
// the lowest-indexed SOF octet.
module ad_ip_jesd204_sof_phase_detect
  import ad_ip_jesd204_link_dnconv_phase_ctrl_pkg::*;
#(
  parameter int OCTETS_PER_BEAT = 8
) (
  input  logic                       i_valid,
  input  logic [OCTETS_PER_BEAT-1:0] i_sof,
  output logic                       o_sof_beat,
  output logic                       o_phase
);

  localparam int IDX_W = (OCTETS_PER_BEAT > 2) ? $clog2(OCTETS_PER_BEAT) : 1;

  logic [IDX_W-1:0] w_low_idx;

  // NOTE: default assignment before the loop keeps this purely combinational (no latch).
  always_comb begin
    w_low_idx = '0;
    for (int i = OCTETS_PER_BEAT - 1; i >= 0; i--) begin
      if (i_sof[i]) w_low_idx = IDX_W'(i);
    end
  end

  assign o_sof_beat = i_valid & (|i_sof);
  assign o_phase    = (o_sof_beat && (w_low_idx >= IDX_W'(OCTETS_PER_BEAT / 2)))
                      ? PHASE_HI : PHASE_LO;

endmodule

// File: rtl/ad_ip_jesd204_link_dnconv_phase_ctrl.sv
// Measures the multiframe period and SOF half-beat phase of the down-converted
// link, locks once both are stable, and flywheels the SOF position in lock.
module ad_ip_jesd204_link_dnconv_phase_ctrl
  import ad_ip_jesd204_link_dnconv_phase_ctrl_pkg::*;
#(
  parameter int OCTETS_PER_BEAT = 8,
  parameter int PERIOD_W        = 10,
  parameter int LOCK_COUNT      = 4,
  parameter int ERR_THRESH      = 2
) (
  input  logic                       link_clk,
  input  logic                       link_resetn,
  input  logic                       enable,
  input  logic                       link_valid,
  input  logic [OCTETS_PER_BEAT-1:0] link_sof,
  input  logic                       clr_err,
  output logic                       phase_sel,
  output logic                       locked,
  output logic [PERIOD_W-1:0]        mf_beats,
  output logic [ERR_CNT_W-1:0]       align_err_cnt,
  output logic [1:0]                 state
);

  state_t                   r_state;
  logic [PERIOD_W-1:0]      r_beat_cnt;
  logic [PERIOD_W-1:0]      r_mf_beats;
  logic                     r_cap_phase;
  logic                     r_period_valid;
  logic [SMALL_CNT_W-1:0]   r_match_cnt;
  logic [SMALL_CNT_W-1:0]   r_miss_cnt;
  logic                     r_phase_sel;
  logic                     r_locked;
  logic [ERR_CNT_W-1:0]     r_align_err_cnt;

  logic                     w_sof_beat;
  logic                     w_phase;
  logic                     w_abort;
  logic                     w_cnt_max;
  logic                     w_expected;
  logic                     w_good;
  logic                     w_mismatch;
  logic [SMALL_CNT_W-1:0]   w_match_next;
  logic [SMALL_CNT_W-1:0]   w_miss_next;

  ad_ip_jesd204_sof_phase_detect #(
    .OCTETS_PER_BEAT(OCTETS_PER_BEAT)
  ) u_sof_phase_detect (
    .i_valid   (link_valid),
    .i_sof     (link_sof),
    .o_sof_beat(w_sof_beat),
    .o_phase   (w_phase)
  );

  assign w_abort    = ~enable | ~link_valid;
  assign w_cnt_max  = &r_beat_cnt;
  assign w_expected = (r_state == ST_LOCKED) && (r_beat_cnt == r_mf_beats);
  assign w_good     = w_expected && w_sof_beat && (w_phase == r_phase_sel);
  // Missing/wrong-phase SOF on the expected beat, or any SOF off it.
  assign w_mismatch = (r_state == ST_LOCKED) && !w_abort &&
                      ((w_expected && !w_good) || (!w_expected && w_sof_beat));
  assign w_miss_next = r_miss_cnt + 1'b1;

  // r_beat_cnt holds the interval since the previous SOF at this point.
  always_comb begin
    w_match_next = SMALL_CNT_W'(1);
    if (r_period_valid && (r_beat_cnt == r_mf_beats)) w_match_next = r_match_cnt + 1'b1;
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge link_clk or negedge link_resetn) begin
    if (!link_resetn) begin
      r_state         <= ST_IDLE;
      r_beat_cnt      <= '0;
      r_mf_beats      <= '0;
      r_cap_phase     <= PHASE_LO;
      r_period_valid  <= 1'b0;
      r_match_cnt     <= '0;
      r_miss_cnt      <= '0;
      r_phase_sel     <= PHASE_LO;
      r_locked        <= 1'b0;
      r_align_err_cnt <= '0;
    end else begin
      // In lock the counter free-runs on the stored period instead of following SOFs.
      if (link_valid) begin
        if ((r_state == ST_LOCKED) ? w_expected : w_sof_beat) r_beat_cnt <= PERIOD_W'(1);
        else if (!w_cnt_max)                                  r_beat_cnt <= r_beat_cnt + 1'b1;
      end

      if (clr_err)                                 r_align_err_cnt <= '0;
      else if (w_mismatch && !(&r_align_err_cnt))  r_align_err_cnt <= r_align_err_cnt + 1'b1;

      if (w_abort) begin
        r_state  <= ST_IDLE;
        r_locked <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: r_state <= ST_SEARCH;

          ST_SEARCH: begin
            if (w_sof_beat) begin
              r_cap_phase    <= w_phase;
              r_period_valid <= 1'b0;
              r_match_cnt    <= '0;
              r_state        <= ST_CHECK;
            end
          end

          ST_CHECK: begin
            if (w_sof_beat) begin
              if (w_phase != r_cap_phase) begin
                r_cap_phase    <= w_phase;
                r_period_valid <= 1'b0;
                r_match_cnt    <= '0;
              end else begin
                if (w_match_next == SMALL_CNT_W'(1)) r_mf_beats <= r_beat_cnt;
                r_period_valid <= 1'b1;
                r_match_cnt    <= w_match_next;
                if (w_match_next == SMALL_CNT_W'(LOCK_COUNT)) begin
                  r_state     <= ST_LOCKED;
                  r_phase_sel <= r_cap_phase;
                  r_locked    <= 1'b1;
                  r_miss_cnt  <= '0;
                end
              end
            end else if (w_cnt_max) begin
              r_state <= ST_SEARCH;
            end
          end

          ST_LOCKED: begin
            if (w_mismatch) begin
              r_miss_cnt <= w_miss_next;
              if (w_miss_next == SMALL_CNT_W'(ERR_THRESH)) begin
                r_state  <= ST_SEARCH;
                r_locked <= 1'b0;
              end
            end else if (w_good) begin
              r_miss_cnt <= '0;
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign phase_sel     = r_phase_sel;
  assign locked        = r_locked;
  assign mf_beats      = r_mf_beats;
  assign align_err_cnt = r_align_err_cnt;
  assign state         = r_state;

endmodule

// File: tb/tb_ad_ip_jesd204_link_dnconv_phase_ctrl.sv
// Directed bench for the down-converter phase controller: lock on both halves,
// jitter restart, in-lock misses, phase flip, abort/clear, reset and timeout.
module tb_ad_ip_jesd204_link_dnconv_phase_ctrl;

  logic       link_clk;
  logic       link_resetn;
  logic       enable;
  logic       link_valid;
  logic [7:0] link_sof;
  logic       clr_err;
  logic       phase_sel;
  logic       locked;
  logic [9:0] mf_beats;
  logic [7:0] align_err_cnt;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  ad_ip_jesd204_link_dnconv_phase_ctrl dut (
    .link_clk     (link_clk),
    .link_resetn  (link_resetn),
    .enable       (enable),
    .link_valid   (link_valid),
    .link_sof     (link_sof),
    .clr_err      (clr_err),
    .phase_sel    (phase_sel),
    .locked       (locked),
    .mf_beats     (mf_beats),
    .align_err_cnt(align_err_cnt),
    .state        (state)
  );

  initial link_clk = 1'b0;
  always #5 link_clk = ~link_clk;

  // One beat: drive, take the rising edge, settle 1 ns so outputs show its effect.
  task automatic step(input logic v, input logic [7:0] sof, input logic clr);
    link_valid = v;
    link_sof   = sof;
    clr_err    = clr;
    @(posedge link_clk);
    #1;
    link_sof = 8'h00;
    clr_err  = 1'b0;
  endtask

  task automatic idle_beats(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    enable      = 1'b0;
    link_valid  = 1'b0;
    link_sof    = 8'h00;
    clr_err     = 1'b0;
    link_resetn = 1'b0;
    repeat (2) @(posedge link_clk);
    #3 link_resetn = 1'b1;
  endtask

  task automatic start_search();
    enable = 1'b1;
    step(1'b1, 8'h00, 1'b0);
  endtask

  // Search entry plus five SOFs 16 beats apart: locks with default parameters.
  task automatic lock_seq(input logic [7:0] sof);
    start_search();
    step(1'b1, sof, 1'b0);
    for (int k = 0; k < 4; k++) begin
      idle_beats(15);
      step(1'b1, sof, 1'b0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (locked !== 1'b0 || phase_sel !== 1'b0) begin errors++; $display("FAIL reset_flags got locked=%0b phase_sel=%0b exp 0 0", locked, phase_sel); end
    checks++; if (mf_beats !== 10'd0 || align_err_cnt !== 8'd0) begin errors++; $display("FAIL reset_counts got mf=%0d err=%0d exp 0 0", mf_beats, align_err_cnt); end
    start_search();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL idle_to_search got %0d exp 1", state); end
  endtask

  task automatic test_lock_upper();
    do_reset();
    start_search();
    step(1'b1, 8'h10, 1'b0);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL hi_search_to_check got %0d exp 2", state); end
    for (int k = 2; k <= 5; k++) begin
      idle_beats(15);
      step(1'b1, 8'h10, 1'b0);
      if (k == 4) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL hi_early_lock got %0b exp 0", locked); end
      end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL hi_locked got %0b exp 1", locked); end
    checks++; if (phase_sel !== 1'b1) begin errors++; $display("FAIL hi_phase_sel got %0b exp 1", phase_sel); end
    checks++; if (mf_beats !== 10'd16) begin errors++; $display("FAIL hi_mf_beats got %0d exp 16", mf_beats); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL hi_state got %0d exp 3", state); end
  endtask

  // Leaves the DUT locked on phase 0, period 16, beat counter just reloaded.
  task automatic test_lock_lower_jitter();
    int gaps[7] = '{16, 16, 15, 16, 16, 16, 16};
    do_reset();
    start_search();
    step(1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 7; i++) begin
      idle_beats(gaps[i] - 1);
      step(1'b1, 8'h01, 1'b0);
      if (i == 2) begin
        checks++; if (mf_beats !== 10'd15) begin errors++; $display("FAIL jit_mf_short got %0d exp 15", mf_beats); end
      end
      if (i == 5) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL jit_early_lock got %0b exp 0", locked); end
      end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL jit_locked got %0b exp 1", locked); end
    checks++; if (phase_sel !== 1'b0) begin errors++; $display("FAIL jit_phase_sel got %0b exp 0", phase_sel); end
    checks++; if (mf_beats !== 10'd16) begin errors++; $display("FAIL jit_mf_beats got %0d exp 16", mf_beats); end
  endtask

  task automatic test_misses();
    idle_beats(15);
    step(1'b1, 8'h00, 1'b0);
    checks++; if (align_err_cnt !== 8'd1) begin errors++; $display("FAIL miss1_err got %0d exp 1", align_err_cnt); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL miss1_locked got %0b exp 1", locked); end
    idle_beats(15);
    step(1'b1, 8'h01, 1'b0);
    idle_beats(15);
    step(1'b1, 8'h00, 1'b0);
    checks++; if (align_err_cnt !== 8'd2 || locked !== 1'b1) begin errors++; $display("FAIL miss2_first got err=%0d locked=%0b exp 2 1", align_err_cnt, locked); end
    idle_beats(15);
    step(1'b1, 8'h00, 1'b0);
    checks++; if (align_err_cnt !== 8'd3) begin errors++; $display("FAIL miss3_err got %0d exp 3", align_err_cnt); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL miss3_unlock got %0b exp 0", locked); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL miss3_state got %0d exp 1", state); end
  endtask

  task automatic test_phase_flip();
    do_reset();
    lock_seq(8'h10);
    idle_beats(15);
    step(1'b1, 8'h01, 1'b0);
    checks++; if (align_err_cnt !== 8'd1 || locked !== 1'b1) begin errors++; $display("FAIL flip1 got err=%0d locked=%0b exp 1 1", align_err_cnt, locked); end
    idle_beats(15);
    step(1'b1, 8'h01, 1'b0);
    checks++; if (align_err_cnt !== 8'd2 || locked !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL flip2 got err=%0d locked=%0b state=%0d exp 2 0 1", align_err_cnt, locked, state); end
    for (int k = 1; k <= 5; k++) begin
      idle_beats(15);
      step(1'b1, 8'h01, 1'b0);
      if (k == 4) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL flip_early_relock got %0b exp 0", locked); end
      end
    end
    checks++; if (locked !== 1'b1 || phase_sel !== 1'b0) begin errors++; $display("FAIL flip_relock got locked=%0b phase_sel=%0b exp 1 0", locked, phase_sel); end
  endtask

  task automatic test_abort_clear();
    do_reset();
    lock_seq(8'h10);
    idle_beats(15);
    step(1'b1, 8'h00, 1'b0);
    idle_beats(15);
    step(1'b1, 8'h10, 1'b0);
    checks++; if (align_err_cnt !== 8'd1) begin errors++; $display("FAIL clr_pre got %0d exp 1", align_err_cnt); end
    idle_beats(15);
    step(1'b1, 8'h00, 1'b1);
    checks++; if (align_err_cnt !== 8'd0 || locked !== 1'b1) begin errors++; $display("FAIL clr_wins got err=%0d locked=%0b exp 0 1", align_err_cnt, locked); end
    idle_beats(3);
    step(1'b0, 8'h00, 1'b0);
    checks++; if (state !== 2'd0 || locked !== 1'b0) begin errors++; $display("FAIL abort got state=%0d locked=%0b exp 0 0", state, locked); end
    checks++; if (mf_beats !== 10'd16 || phase_sel !== 1'b1) begin errors++; $display("FAIL abort_retain got mf=%0d phase_sel=%0b exp 16 1", mf_beats, phase_sel); end
  endtask

  task automatic test_reset_timeout();
    do_reset();
    start_search();
    step(1'b1, 8'h10, 1'b0);
    idle_beats(15);
    step(1'b1, 8'h10, 1'b0);
    idle_beats(5);
    checks++; if (state !== 2'd2 || mf_beats !== 10'd16) begin errors++; $display("FAIL pre_reset got state=%0d mf=%0d exp 2 16", state, mf_beats); end
    #1 link_resetn = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || mf_beats !== 10'd0 || locked !== 1'b0 || phase_sel !== 1'b0 || align_err_cnt !== 8'd0)
      begin errors++; $display("FAIL async_reset got state=%0d mf=%0d locked=%0b phase=%0b err=%0d exp all 0", state, mf_beats, locked, phase_sel, align_err_cnt); end
    #2 link_resetn = 1'b1;
    start_search();
    step(1'b1, 8'h10, 1'b0);
    idle_beats(1022);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL timeout_early got %0d exp 2", state); end
    idle_beats(1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL timeout got %0d exp 1", state); end
  endtask

  initial begin
    link_resetn = 1'b0;
    enable      = 1'b0;
    link_valid  = 1'b0;
    link_sof    = 8'h00;
    clr_err     = 1'b0;
    test_reset();
    test_lock_upper();
    test_lock_lower_jitter();
    test_misses();
    test_phase_flip();
    test_abort_clear();
    test_reset_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad_ip_jesd204_link_dnconv_phase_ctrl.md
# ad_ip_jesd204_link_dnconv_phase_ctrl

Single-clock controller that sequences the JESD204 link down-converter. It sits in the slow (output) link clock domain, after the down-converted beat. It monitors the start-of-frame (SOF) markers, measures the multiframe period in beats and determines on which half of the wide beat the SOF lands. Once SOF phase and period are stable it asserts `locked` and drives `phase_sel`, so downstream lane alignment can shift by half a beat. In lock, a flywheel counter tracks each expected SOF and the block relocks on persistent errors.

## Interface
Parameters:
- `OCTETS_PER_BEAT`, 8: octets per output beat; must be even.
- `PERIOD_W`, 10: width of the beat counter and the stored multiframe period.
- `LOCK_COUNT`, 4: consecutive matching SOF intervals required to lock (1..15).
- `ERR_THRESH`, 2: consecutive mismatching SOF events in lock that force a relock (1..15).

Ports:
- `link_clk`, in, 1: single clock for the block.
- `link_resetn`, in, 1: reset, asynchronous and active-low.
- `enable`, in, 1: run control; low forces IDLE.
- `link_valid`, in, 1: down-converted beat valid.
- `link_sof`, in, `OCTETS_PER_BEAT`: SOF per octet of the current beat.
- `clr_err`, in, 1: single-cycle pulse that clears `align_err_cnt`.
- `phase_sel`, out, 1: 0 means SOF is in the lower half; 1 means SOF is in the upper half.
- `locked`, out, 1: phase and period are stable.
- `mf_beats`, out, `PERIOD_W`: measured multiframe period in beats.
- `align_err_cnt`, out, 8: saturating count of in-lock SOF mismatches.
- `state`, out, 2: current state (IDLE=0, SEARCH=1, CHECK=2, LOCKED=3).

## Operation
- **SOF beat:** `link_valid & |link_sof`.
- **Beat phase:** 1 if the lowest set bit index of `link_sof` is >= `OCTETS_PER_BEAT/2`, otherwise 0.
- **`beat_cnt` (PERIOD_W):**
  - Loads 1 on a SOF beat.
  - Otherwise increments on each valid beat and saturates at all-ones.
  - At a SOF beat, its pre-load value is the interval in beats.
- **IDLE:** goes to SEARCH when `enable & link_valid`.
- **SEARCH:** on a SOF beat, captures the phase into `cap_phase`, clears `period_valid` and `match_cnt`, and goes to CHECK.
- **CHECK, on a SOF beat:**
  - Phase differs from `cap_phase`: recapture the phase, clear `period_valid` and set `match_cnt`=0. Stay in CHECK.
  - `period_valid`=0: store the interval in `mf_beats`, set `period_valid`=1 and set `match_cnt`=1.
  - Interval equals `mf_beats`: `match_cnt`++.
  - Interval differs: store the new interval and set `match_cnt`=1.
  - If `match_cnt` reaches `LOCK_COUNT`: go to LOCKED, load `phase_sel`=`cap_phase` and set `locked`=1.
- **CHECK timeout:** `beat_cnt` saturating without a SOF goes to SEARCH.
- **LOCKED, expected beat:** the beat where `beat_cnt == mf_beats`; at this beat `beat_cnt` reloads to 1 (flywheel).
  - SOF with matching phase on the expected beat: good; clears `miss_cnt`.
  - Any of the following is a mismatch: no SOF on the expected beat, a SOF on any other beat, or a SOF with the wrong phase.
  - Each mismatch increments `align_err_cnt` (saturating at 255) and increments `miss_cnt`.
  - When `miss_cnt` reaches `ERR_THRESH`: go to SEARCH and set `locked`=0.
- **Abort:** `enable`=0 or `link_valid`=0 in any state goes to IDLE with `locked`=0. This has priority over all other transitions.
- **Retention:** `phase_sel` and `mf_beats` keep their last value outside LOCKED. They are qualified only by `locked`.
- **Error clear:** `clr_err` clears `align_err_cnt`. If it coincides with a mismatch, the clear wins (result 0).

## Timing
- All outputs are registered; the reset value of every output is 0.
- Outputs update one cycle after the beat that causes the change.
- Lock latency: `locked` rises the cycle after the (`LOCK_COUNT`+1)-th SOF beat counted from SEARCH entry.
- Unlock latency: `locked` falls the cycle after the `ERR_THRESH`-th consecutive mismatch.
- Reset assertion mid-operation clears everything immediately. After reset release, operation restarts from IDLE.
- Minimum supported period is 2 beats. A SOF on consecutive beats in CHECK stores interval 1 and is treated normally.

## Structure
- Shared package: state encodings, the phase constants (`PHASE_LO`/`PHASE_HI`) and the `align_err_cnt` width.
- One sub-module `ad_ip_jesd204_sof_phase_detect`: a parameterized lowest-set-bit encoder that produces the SOF-beat flag and the beat phase.
- The FSM, counters and flywheel live in the top module.

## Test plan
- **Lock, upper phase:** period 16, `link_sof`=8'h10 every 16 beats, defaults. Expect `locked`=1 the cycle after the 5th SOF, `phase_sel`=1, `mf_beats`=16 and `state`=3.
- **Lock, lower phase with jitter:** period 16 with `link_sof`=8'h01, but the 3rd interval is 15. Expect `match_cnt` to restart and lock after the 8th SOF; `phase_sel`=0.
- **In-lock misses:** after lock, drop one SOF. Expect `align_err_cnt`=1 and `locked` held. Then drop two consecutive SOFs. Expect `align_err_cnt`=3, `locked`=0 after the second miss, and `state`=1.
- **Phase flip:** after lock, SOF moves to 8'h01. Expect two errors, unlock, then relock with `phase_sel`=0 after 5 more SOFs.
- **Abort and clear:** `link_valid` drops in LOCKED. Expect `state`=0 and `locked`=0 next cycle. `clr_err` coincident with a mismatch gives `align_err_cnt`=0.
- **Async reset and timeout:** assert `link_resetn` mid-CHECK; expect all outputs 0 without a clock edge. After release, no SOF for 1023 beats in CHECK gives a return to SEARCH.
